// File: rtl/sram2rw_port_arbiter.sv
// Two-requester arbiter for a 64x32 dual-port SRAM macro: post-reset fill sweep, round-robin same-address collisions.
// Optional collision counter enabled by SRAM_ARB_CONFLICT_CNT_EN (adds conflict_clr / conflict_cnt ports).

module sram2rw_port_lane #(
    parameter logic [31:0] INIT_VALUE = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        grant,
    input  logic        we,
    input  logic [5:0]  addr,
    input  logic [31:0] wdata,
    input  logic        sweep_en,
    input  logic [5:0]  sweep_addr,
    input  logic [31:0] sram_o,
    output logic [5:0]  sram_a,
    output logic        sram_csb,
    output logic        sram_web,
    output logic        sram_oeb,
    output logic [31:0] sram_i,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata
);
    logic        sweep_q;
    logic [5:0]  a_q;
    logic [31:0] i_q;
    logic        rsp_q;
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sweep_q <= 1'b0;
            a_q     <= '0;
            i_q     <= '0;
            rsp_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            sweep_q <= sweep_en;
            rsp_q   <= grant & ~we;
            if (rsp_q)
                rdata_q <= sram_o;
            if (sweep_en) begin
                a_q <= sweep_addr;
                i_q <= INIT_VALUE;
            end else if (grant) begin
                a_q <= addr;
                i_q <= wdata;
            end
        end
    end

    // Sweep drives the macro from registers; RUN traffic goes straight through so the macro samples it at the accept edge.
    assign sram_csb  = ~(sweep_q | grant);
    assign sram_web  = ~(sweep_q | (grant & we));
    assign sram_a    = grant ? addr : a_q;
    assign sram_i    = grant ? wdata : i_q;
    assign sram_oeb  = ~rsp_q;
    assign rsp_valid = rsp_q;
    assign rsp_rdata = rsp_q ? sram_o : rdata_q;
endmodule

module sram2rw_port_arbiter #(
    parameter int          INIT_ON_RESET = 1,
    parameter logic [31:0] INIT_VALUE    = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_we,
    input  logic [5:0]  req0_addr,
    input  logic [31:0] req0_wdata,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_we,
    input  logic [5:0]  req1_addr,
    input  logic [31:0] req1_wdata,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_rdata,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_rdata,
    output logic        init_done,
    output logic [5:0]  sram_a1,
    output logic [5:0]  sram_a2,
    output logic        sram_csb1,
    output logic        sram_csb2,
    output logic        sram_web1,
    output logic        sram_web2,
    output logic        sram_oeb1,
    output logic        sram_oeb2,
    output logic [31:0] sram_i1,
    output logic [31:0] sram_i2,
    input  logic [31:0] sram_o1,
    input  logic [31:0] sram_o2
`ifdef SRAM_ARB_CONFLICT_CNT_EN
    ,
    input  logic        conflict_clr,
    output logic [15:0] conflict_cnt
`endif
);
    typedef enum logic [1:0] {S_INIT, S_DONE, S_RUN} state_t;

    state_t     state;
    logic [4:0] cnt;
    logic       rr;
    logic       run, coll, sweep_en;

    logic [1:0]       valid, we, grant, csb, web, oeb, rvld;
    logic [1:0][5:0]  addr, a, sweep_addr;
    logic [1:0][31:0] wdata, i, o, rdata;

    assign valid = {req1_valid, req0_valid};
    assign we    = {req1_we, req0_we};
    assign addr  = {req1_addr, req0_addr};
    assign wdata = {req1_wdata, req0_wdata};
    assign o     = {sram_o2, sram_o1};

    // Gated by rst_n so nothing is granted on the edge that resets the block.
    assign run      = rst_n && (state == S_RUN);
    assign sweep_en = rst_n && (state == S_INIT);
    assign coll     = run & valid[0] & valid[1] & (addr[0] == addr[1]) & (we[0] | we[1]);
    assign grant[0] = run & valid[0] & ~(coll & rr);
    assign grant[1] = run & valid[1] & ~(coll & ~rr);
    assign sweep_addr[0] = {1'b0, cnt};
    assign sweep_addr[1] = {1'b1, cnt};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= (INIT_ON_RESET != 0) ? S_INIT : S_RUN;
            cnt       <= '0;
            rr        <= 1'b0;
            init_done <= (INIT_ON_RESET == 0);
        end else begin
            case (state)
                S_INIT: begin
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31)
                        state <= S_DONE;
                end
                // One idle cycle lets the registered c=31 write reach the macro before traffic.
                S_DONE: begin
                    state     <= S_RUN;
                    init_done <= 1'b1;
                end
                default: begin
                    if (coll)
                        rr <= ~rr;
                end
            endcase
        end
    end

`ifdef SRAM_ARB_CONFLICT_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            conflict_cnt <= '0;
        else if (conflict_clr)
            conflict_cnt <= '0;
        else if (coll && conflict_cnt != 16'hFFFF)
            conflict_cnt <= conflict_cnt + 16'd1;
    end
`endif

    for (genvar p = 0; p < 2; p++) begin : g_lane
        sram2rw_port_lane #(.INIT_VALUE(INIT_VALUE)) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .grant      (grant[p]),
            .we         (we[p]),
            .addr       (addr[p]),
            .wdata      (wdata[p]),
            .sweep_en   (sweep_en),
            .sweep_addr (sweep_addr[p]),
            .sram_o     (o[p]),
            .sram_a     (a[p]),
            .sram_csb   (csb[p]),
            .sram_web   (web[p]),
            .sram_oeb   (oeb[p]),
            .sram_i     (i[p]),
            .rsp_valid  (rvld[p]),
            .rsp_rdata  (rdata[p])
        );
    end

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign rsp0_valid = rvld[0];
    assign rsp1_valid = rvld[1];
    assign rsp0_rdata = rdata[0];
    assign rsp1_rdata = rdata[1];
    assign sram_a1    = a[0];
    assign sram_a2    = a[1];
    assign sram_csb1  = csb[0];
    assign sram_csb2  = csb[1];
    assign sram_web1  = web[0];
    assign sram_web2  = web[1];
    assign sram_oeb1  = oeb[0];
    assign sram_oeb2  = oeb[1];
    assign sram_i1    = i[0];
    assign sram_i2    = i[1];
endmodule
